// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO for the UART transmit/receive paths, with a two-stage registered read,
// run-time almost-full/almost-empty thresholds, fill count, flush and sticky error flags.
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  WRB,
    input  logic                  RDB,
    input  logic                  FLUSH,
    input  logic [ADDR_WIDTH:0]   AF_THRESH,
    input  logic [ADDR_WIDTH:0]   AE_THRESH,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  AFULL,
    output logic                  AEMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [DATA_WIDTH-1:0] rdReg;
    logic                  rdPending;
    logic                  wrAccept;
    logic                  rdAccept;
    logic [ADDR_WIDTH:0]   countNext;

    // A read frees a slot in the same cycle, so a full FIFO still takes a simultaneous write.
    always_comb begin
        rdAccept  = !RDB && !EMPTY;
        wrAccept  = !WRB && (!FULL || rdAccept);
        countNext = COUNT;
        if (FLUSH)
            countNext = '0;
        else if (wrAccept && !rdAccept)
            countNext = COUNT + COUNT_ONE;
        else if (rdAccept && !wrAccept)
            countNext = COUNT - COUNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (wrAccept && !FLUSH)
            mem[wrPtr] <= DATA_IN;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            rdReg     <= '0;
            rdPending <= 1'b0;
            DATA_OUT  <= '0;
            COUNT     <= '0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            AFULL     <= 1'b0;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (FLUSH) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            rdPending <= 1'b0;
            COUNT     <= '0;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            AFULL     <= 1'b0;
            AEMPTY    <= 1'b1;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wrAccept)
                wrPtr <= wrPtr + PTR_ONE;
            if (rdAccept) begin
                rdPtr <= rdPtr + PTR_ONE;
                rdReg <= mem[rdPtr];
            end
            // Second read stage: DATA_OUT only moves one edge after an accepted read.
            rdPending <= rdAccept;
            if (rdPending)
                DATA_OUT <= rdReg;
            if (!WRB && !wrAccept)
                OVERFLOW <= 1'b1;
            if (!RDB && !rdAccept)
                UNDERFLOW <= 1'b1;
            COUNT  <= countNext;
            FULL   <= (countNext == FULL_LEVEL);
            EMPTY  <= (countNext == '0);
            AFULL  <= (countNext >= AF_THRESH);
            AEMPTY <= (countNext <= AE_THRESH);
        end
    end

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: a constant vector table for the basic corner cases, then a
// queue-based reference model checks every output on every cycle of the longer sequences.
module tb_uart_sync_fifo;

    localparam int DEPTH = 256;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       WRB;
    logic       RDB;
    logic       FLUSH;
    logic [8:0] AF_THRESH;
    logic [8:0] AE_THRESH;
    logic [7:0] DATA_OUT;
    logic       FULL;
    logic       EMPTY;
    logic       AFULL;
    logic       AEMPTY;
    logic [8:0] COUNT;
    logic       OVERFLOW;
    logic       UNDERFLOW;

    uart_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .WRB(WRB), .RDB(RDB), .FLUSH(FLUSH),
        .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH), .DATA_OUT(DATA_OUT), .FULL(FULL),
        .EMPTY(EMPTY), .AFULL(AFULL), .AEMPTY(AEMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: FIFO contents as a queue, plus the two read stages
    logic [7:0] mq[$];
    logic [7:0] mRd;
    logic [7:0] mOut;
    logic       mPend;
    logic       mOvf;
    logic       mUnf;

    typedef struct {
        logic       wrb;
        logic       rdb;
        logic       flush;
        logic [7:0] din;
        int         expCount;
        logic       expEmpty;
        logic [7:0] expDout;
        logic       expUnf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, actual, actual, expected, expected);
    endtask

    task automatic modelReset();
        mq.delete();
        mRd   = 8'h00;
        mOut  = 8'h00;
        mPend = 1'b0;
        mOvf  = 1'b0;
        mUnf  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, leave time at edge+1
    task automatic applyStimulus(input logic wrb, input logic rdb, input logic flush,
                                 input logic [7:0] din);
        logic rdOk;
        logic wrOk;
        WRB     = wrb;
        RDB     = rdb;
        FLUSH   = flush;
        DATA_IN = din;
        @(posedge CLK);
        if (flush) begin
            mq.delete();
            mOvf  = 1'b0;
            mUnf  = 1'b0;
            mPend = 1'b0;
        end else begin
            rdOk = !rdb && (mq.size() != 0);
            wrOk = !wrb && ((mq.size() != DEPTH) || rdOk);
            if (mPend)
                mOut = mRd;
            mPend = rdOk;
            if (rdOk)
                mRd = mq.pop_front();
            if (wrOk)
                mq.push_back(din);
            if (!wrb && !wrOk)
                mOvf = 1'b1;
            if (!rdb && !rdOk)
                mUnf = 1'b1;
        end
        #1;
        WRB   = 1'b1;
        RDB   = 1'b1;
        FLUSH = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        int n;
        n = mq.size();
        check({tag, " COUNT"}, int'(COUNT), n);
        check({tag, " EMPTY"}, int'(EMPTY), int'(n == 0));
        check({tag, " FULL"}, int'(FULL), int'(n == DEPTH));
        check({tag, " AFULL"}, int'(AFULL), int'(n >= int'(AF_THRESH)));
        check({tag, " AEMPTY"}, int'(AEMPTY), int'(n <= int'(AE_THRESH)));
        check({tag, " DATA_OUT"}, int'(DATA_OUT), int'(mOut));
        check({tag, " OVERFLOW"}, int'(OVERFLOW), int'(mOvf));
        check({tag, " UNDERFLOW"}, int'(UNDERFLOW), int'(mUnf));
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " DATA_OUT"}, int'(DATA_OUT), 0);
        check({tag, " COUNT"}, int'(COUNT), 0);
        check({tag, " EMPTY"}, int'(EMPTY), 1);
        check({tag, " AEMPTY"}, int'(AEMPTY), 1);
        check({tag, " FULL"}, int'(FULL), 0);
        check({tag, " AFULL"}, int'(AFULL), 0);
        check({tag, " OVERFLOW"}, int'(OVERFLOW), 0);
        check({tag, " UNDERFLOW"}, int'(UNDERFLOW), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h5C, 1, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h11, 1, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h22, 2, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h11, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h11, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h22, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 8'h22, 1'b1};

        RESET     = 1'b1;
        WRB       = 1'b1;
        RDB       = 1'b1;
        FLUSH     = 1'b0;
        DATA_IN   = 8'h00;
        AF_THRESH = 9'd256;
        AE_THRESH = 9'd0;
        modelReset();
        #1;
        checkResetValues("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Constant vectors: underflow, empty write+read, flush, two-edge read latency
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].wrb, vecs[i].rdb, vecs[i].flush, vecs[i].din);
            check($sformatf("vec%0d COUNT", i), int'(COUNT), vecs[i].expCount);
            check($sformatf("vec%0d EMPTY", i), int'(EMPTY), int'(vecs[i].expEmpty));
            check($sformatf("vec%0d DATA_OUT", i), int'(DATA_OUT), int'(vecs[i].expDout));
            check($sformatf("vec%0d UNDERFLOW", i), int'(UNDERFLOW), int'(vecs[i].expUnf));
        end

        // Fill 0x00..0xFF, overflow, full write+read, drain
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        checkOutput("flush1");
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i));
            checkOutput($sformatf("fill%0d", i));
        end
        check("full COUNT", int'(COUNT), 256);
        check("full FULL", int'(FULL), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hEE);
        checkOutput("ovf");
        check("ovf OVERFLOW", int'(OVERFLOW), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA);
        checkOutput("fullrw");
        check("fullrw COUNT", int'(COUNT), 256);
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("drain%0d", i));
        end
        check("drain last DATA_OUT", int'(DATA_OUT), 8'hAA);
        check("drain EMPTY", int'(EMPTY), 1);

        // Empty: lone read underflows, write+read only writes
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("unf");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h5C);
        checkOutput("emptyrw");
        check("emptyrw COUNT", int'(COUNT), 1);

        // Thresholds: AF=200, AE=4, fill then drain one word per cycle
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
        AF_THRESH = 9'd200;
        AE_THRESH = 9'd4;
        for (int i = 0; i < 210; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
            checkOutput($sformatf("thfill%0d", i));
            if (i == 4)
                check("count5 AEMPTY", int'(AEMPTY), 0);
            if (i == 199)
                check("count200 AFULL", int'(AFULL), 1);
        end
        for (int i = 0; i < 212; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
            checkOutput($sformatf("thdrain%0d", i));
        end

        // Fill 100, flush together with a write, then write/read new data
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(i + 1));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h99);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33);
        checkOutput("flushwr");
        check("flushwr COUNT", int'(COUNT), 0);
        check("flushwr EMPTY", int'(EMPTY), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h77);
        checkOutput("postflush wr");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("postflush rd");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("postflush out");
        check("postflush DATA_OUT", int'(DATA_OUT), 8'h77);

        // Pointer wrap with COUNT held at 3
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
            checkOutput($sformatf("wrap%0d", i));
        end

        // Asynchronous reset in the middle of a write/read burst
        WRB     = 1'b0;
        RDB     = 1'b0;
        DATA_IN = 8'h5A;
        @(posedge CLK);
        #3;
        RESET = 1'b1;
        #1;
        checkResetValues("midreset");
        modelReset();
        WRB = 1'b1;
        RDB = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C);
        checkOutput("afterreset wr");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h4D);
        checkOutput("afterreset rw");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("afterreset rd");
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("afterreset out");
        check("afterreset DATA_OUT", int'(DATA_OUT), 8'h4D);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_sync_fifo.md
# uart_sync_fifo

Parametrised single-clock FIFO for the CoreUARTapb transmit and receive data paths. It replaces the fixed 256x8 hard-macro FIFO with inferred storage of configurable width and depth. Over the fixed FIFO it adds run-time almost-full and almost-empty thresholds, a fill-level count, synchronous flush, and sticky overflow/underflow error flags. Read data keeps the registered-output behaviour the UART control logic already expects.

## Interface
- DATA_WIDTH, 8, word width in bits (1..32)
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2**ADDR_WIDTH (2..1024 words)

Ports:
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- DATA_IN  in  DATA_WIDTH  write data
- WRB  in  1  write strobe, active-low, sampled on CLK
- RDB  in  1  read strobe, active-low, sampled on CLK
- FLUSH  in  1  synchronous clear, active-high
- AF_THRESH  in  ADDR_WIDTH+1  almost-full level, legal 1..DEPTH
- AE_THRESH  in  ADDR_WIDTH+1  almost-empty level, legal 0..DEPTH-1
- DATA_OUT  out  DATA_WIDTH  registered read data
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- AFULL  out  1  COUNT >= AF_THRESH
- AEMPTY  out  1  COUNT <= AE_THRESH
- COUNT  out  ADDR_WIDTH+1  words stored
- OVERFLOW  out  1  sticky: write rejected because FIFO was full
- UNDERFLOW  out  1  sticky: read rejected because FIFO was empty

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer and read pointer of ADDR_WIDTH bits each, plus COUNT register. Pointers wrap modulo DEPTH.
- Accepted write: WRB=0 and (FULL=0, or a read is accepted in the same cycle). Stores DATA_IN at the write pointer; the write pointer increments.
- Accepted read: RDB=0 and EMPTY=0. Loads the word at the read pointer into an internal read register; the read pointer increments.
- Both accepted in one cycle: COUNT is unchanged.
  - FULL with simultaneous read and write: both are accepted, no overflow.
  - EMPTY with simultaneous read and write: only the write is accepted, and UNDERFLOW is set. There is no fall-through.
- COUNT: +1 on write only, -1 on read only, otherwise held. It never exceeds DEPTH and never goes below 0.
- Rejected write (WRB=0, FULL=1, no accepted read): storage and pointers are unchanged, and OVERFLOW is set.
- Rejected read (RDB=0, EMPTY=1): pointers and DATA_OUT are unchanged, and UNDERFLOW is set.
- Flags FULL, EMPTY, AFULL and AEMPTY are registered and computed from the next-state COUNT, so they are valid in the same cycle as COUNT.
- AF_THRESH and AE_THRESH are quasi-static. A change takes effect at the next CLK edge. Values outside the legal range give undefined AFULL/AEMPTY.
- FLUSH=1 has priority over WRB and RDB in the same cycle. It clears both pointers, COUNT, OVERFLOW and UNDERFLOW, sets EMPTY=1 and AEMPTY=1, and clears FULL and AFULL. DATA_OUT holds its value. Array contents are don't-care.
- OVERFLOW and UNDERFLOW clear only on RESET or FLUSH.

## Timing
- Reset values (asynchronous, immediate): DATA_OUT=0, COUNT=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0, pointers=0.
- Read latency is 2 edges:
  - The read is accepted at edge N, and the internal read register loads at N.
  - DATA_OUT loads from the read register at edge N+1 and holds until the next accepted read propagates.
- Write-to-flags latency is 1 edge: after a write accepted at edge N into an empty FIFO, EMPTY=0 and COUNT=1 from edge N onward.
- Read-after-write: a word written at edge N can be read at edge N+1 at the earliest, so DATA_OUT is valid after edge N+2.
- Back-to-back reads on every cycle are supported, giving one word per cycle on DATA_OUT after the 2-edge fill.
- RESET released mid-operation: the first edge after release behaves as a normal cycle from the reset state.

## Test plan
- Defaults; write 0x00..0xFF on 256 consecutive cycles. FULL rises after the 256th edge with COUNT=256. Then read 256 on consecutive cycles: DATA_OUT sequence is 0x00..0xFF starting 2 edges after the first read, EMPTY=1 after the last read, no error flags.
- Full FIFO, a 257th write with WRB=0, RDB=1 -> OVERFLOW=1 and COUNT stays 256. Then simultaneous write of 0xAA and read -> COUNT stays 256, no new error, and 0xAA appears after 256 further reads.
- Empty FIFO, RDB=0 alone -> UNDERFLOW=1 and DATA_OUT unchanged. Simultaneous write of 0x5C and read when empty -> COUNT=1 and DATA_OUT unchanged.
- AF_THRESH=200, AE_THRESH=4: fill one word per cycle.
  - AEMPTY goes 0 on the edge where COUNT becomes 5.
  - AFULL goes 1 on the edge where COUNT becomes 200.
  - Draining mirrors both transitions.
- Fill 100 words, then pulse FLUSH together with WRB=0 -> COUNT=0, EMPTY=1, error flags cleared, and the simultaneous write is discarded. A subsequent write/read returns the new data.
- Pointer wrap: repeat 300 cycles of simultaneous write/read with COUNT held at 3 -> data order is preserved across the pointer wrap. Assert RESET mid-burst -> all outputs take their reset values immediately.
